// File: rtl/flash_loader.sv
// Boot-time loader: turns a byte stream (16-bit word count + little-endian words)
// into single-cycle instruction-memory writes, holding the core in reset until done.
module flash_loader #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             flash_en,
  output logic [10:0]      flash_addr,
  output logic [WIDTH-1:0] flash_data,
  output logic             cpu_hold,
  output logic             done,
  output logic             error
);

  if (WIDTH != 32) begin : g_bad_width
    $error("flash_loader supports WIDTH = 32 only");
  end

  typedef enum logic [2:0] {CNT_LO, CNT_HI, DATA, WRITE, DONE, ERROR} state_t;

  state_t      state, state_nx;
  logic [15:0] n;
  logic [1:0]  bcnt;
  logic [11:0] idx;
  logic [23:0] lanes;
  logic        xfer;
  logic [15:0] n_full;
  logic        last_word;

  assign in_ready  = (state == CNT_LO) || (state == CNT_HI) || (state == DATA);
  assign flash_en  = (state == WRITE);
  assign xfer      = in_valid && in_ready;
  assign n_full    = {in_data, n[7:0]};
  assign last_word = (({4'd0, idx} + 16'd1) == n);

  always_ff @(posedge clk) begin
    if (rst) state <= CNT_LO;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      CNT_LO: if (xfer) state_nx = CNT_HI;
      CNT_HI: if (xfer) begin
        if (n_full == 16'd0)         state_nx = DONE;
        else if (n_full > 16'd2048)  state_nx = ERROR;
        else                         state_nx = DATA;
      end
      DATA:   if (xfer && bcnt == 2'd3) state_nx = WRITE;
      WRITE:  state_nx = last_word ? DONE : DATA;
      default: state_nx = state;
    endcase
  end

  // Status flags are registered off the next state so they assert on the first cycle in DONE/ERROR.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      cpu_hold <= (state_nx != DONE);
      done     <= (state_nx == DONE);
      error    <= (state_nx == ERROR);
    end
  end

  // The 4th byte lands directly in flash_data, so the write fires the very next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      n          <= '0;
      bcnt       <= '0;
      idx        <= '0;
      lanes      <= '0;
      flash_addr <= '0;
      flash_data <= '0;
    end else begin
      case (state)
        CNT_LO: if (xfer) n[7:0]  <= in_data;
        CNT_HI: if (xfer) n[15:8] <= in_data;
        DATA: if (xfer) begin
          bcnt <= bcnt + 2'd1;
          if (bcnt == 2'd3) begin
            flash_data <= {in_data, lanes};
            flash_addr <= idx[10:0];
          end else begin
            lanes[8*bcnt +: 8] <= in_data;
          end
        end
        WRITE: idx <= idx + 12'd1;
        default: ;
      endcase
    end
  end

endmodule
